// File: rtl/booth_mul_iter.sv
// -----------------------------------------------------------------------------
// booth_mul_iter
//
// Iterative 32x32 -> 64 multiplier using radix-4 Booth recoding. One Booth
// digit (one partial product) is retired per clock. The operation can be
// signed or unsigned, and the choice is made per request.
//
// Both operands are extended to 34 bits (sign or zero, per mul_signed). This
// makes the unsigned case a plain signed multiply of non-negative values.
// A 34-bit multiplier yields 17 Booth digits. Every operation therefore takes
// exactly 17 BUSY cycles, with no early termination.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   x           multiplicand, sampled on the accept edge only
//   y           multiplier, sampled on the accept edge only
//   mul_signed  1 = two's-complement operands, 0 = unsigned (accept edge only)
//   in_valid    request valid
//   in_ready    block idle and able to accept a request
//   out_valid   product valid, held until consumed
//   out_ready   consumer accepts the product
//   p           64-bit product, holds its value until the next completion
// -----------------------------------------------------------------------------
module booth_mul_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        mul_signed,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p
);

    // Accumulator width. The true product always fits in 64 bits. The extra
    // bits let the Booth sums wrap without losing information, and the
    // modulo-2^68 result's low 64 bits are the exact product.
    localparam int ACC_W = 68;
    localparam logic [4:0] LAST_DIGIT = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [4:0]       count;   // index of the Booth digit being retired
    logic [ACC_W-1:0] mcand;   // extended multiplicand, pre-scaled by 4^count
    logic [34:0]      mplier;  // {y_ext, 1'b0}, shifted right 2 bits per digit
    logic [ACC_W-1:0] acc;

    logic accept;
    logic last_digit;

    // Operand extension on the accept edge
    logic [33:0] x_ext;
    logic [33:0] y_ext;

    assign x_ext = {{2{mul_signed & x[31]}}, x};
    assign y_ext = {{2{mul_signed & y[31]}}, y};

    assign accept     = in_valid & in_ready;
    assign last_digit = (state == ST_BUSY) && (count == LAST_DIGIT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. No path can leave
    // a signal unassigned, so no latches are inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count == LAST_DIGIT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Booth digit decode and partial-product add
    // -------------------------------------------------------------------------
    // The triplet {y[2c+1], y[2c], y[2c-1]} sits in mplier[2:0]. Because
    // mplier starts as {y_ext, 1'b0}, the implicit y[-1] = 0 is already in
    // place for digit 0.
    logic [2:0]       triplet;
    logic [ACC_W-1:0] pp_sel;
    logic             pp_neg;
    logic [ACC_W-1:0] pp_term;
    logic [ACC_W-1:0] acc_sum;

    always_comb begin
        triplet = mplier[2:0];
        pp_sel  = '0;
        pp_neg  = 1'b0;

        case (triplet)
            3'b001, 3'b010: begin               // +X
                pp_sel = mcand;
            end
            3'b011: begin                       // +2X
                pp_sel = mcand << 1;
            end
            3'b100: begin                       // -2X
                pp_sel = mcand << 1;
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin               // -X
                pp_sel = mcand;
                pp_neg = 1'b1;
            end
            default: begin                      // 000 / 111 -> 0
                pp_sel = '0;
                pp_neg = 1'b0;
            end
        endcase

        // Negation is the one's complement plus a carry-in of 1. The two
        // together form -pp_sel modulo 2^ACC_W, so no separate negator is
        // needed.
        pp_term = pp_neg ? ~pp_sel : pp_sel;
        acc_sum = acc + pp_term + {{(ACC_W-1){1'b0}}, pp_neg};
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the datapath registers are reset together with the control state.
    // The product register is architecturally visible, and it must read zero
    // after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand  <= {{(ACC_W-34){x_ext[33]}}, x_ext};
                        mplier <= {y_ext, 1'b0};
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                ST_BUSY: begin
                    acc    <= acc_sum;
                    // Scaling the multiplicand by 4 gives the next digit its
                    // 4^count weight. Shifting the multiplier by 2 brings the
                    // next triplet into bits [2:0].
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    count  <= count + 5'd1;
                    if (last_digit) begin
                        p <= acc_sum[63:0];
                    end
                end
                default: begin
                    // DONE: p holds steady until it is consumed, and the
                    // operand inputs are ignored.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_iter
//
// Self-checking bench for booth_mul_iter. The first part is a table of
// directed vectors with known products. A few hand-written sequences follow:
// backpressure, out_ready high at completion, and reset mid-operation. The
// last part is a randomized regression against a plain 64-bit multiply.
// -----------------------------------------------------------------------------
module tb_booth_mul_iter;

    logic        clk;
    logic        reset;
    logic [31:0] x;
    logic [31:0] y;
    logic        mul_signed;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mul_iter dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .mul_signed (mul_signed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product, computed at the integer level from the operand
    // interpretation.
    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request when the block is idle, and return right after the
    // accept edge. The operands are then scrambled to show they are not
    // re-sampled.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        x          = a;
        y          = b;
        mul_signed = s;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        x          = $urandom;
        y          = $urandom;
        mul_signed = 1'($urandom);
    endtask

    // Count the edges from the accept edge until out_valid is seen. The wait
    // is bounded, and -1 is returned if out_valid never appears.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            if (!seen) begin
                @(posedge clk); #1;
                x = $urandom;
                y = $urandom;
                if (out_valid) begin
                    seen = 1'b1;
                    lat  = k;
                end
            end
        end
    endtask

    // Stall for a number of cycles, then consume the product.
    task automatic consume(input int stall, input logic [63:0] held);
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_p", p, held);
            check("stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_valid", 64'(out_valid), 64'd0);
        check("consume_ready", 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] corners[5];
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;

        corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                    32'h8000_0000, 32'h7FFF_FFFF};

        vecs[0] = '{"u_max_sq",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{"s_min_sq",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[2] = '{"u_min_sq",  32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
        vecs[3] = '{"s_m1_x1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{"u_m1_x1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{"s_zero",    32'h8000_0000, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000};
        vecs[6] = '{"s_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        x          = '0;
        y          = '0;
        mul_signed = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", p, 64'h0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'd17);
            check(vecs[i].name, p, vecs[i].exp);
            check({vecs[i].name, "_busy_ready"}, 64'(in_ready), 64'd0);
            consume(1, vecs[i].exp);
        end

        // Backpressure: the product is stalled for 10 cycles while a new
        // request is held. The new request is accepted only after the
        // product is consumed.
        start_op(32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_done(lat);
        check("bp_lat", 64'(lat), 64'd17);
        check("bp_p", p, 64'hFFFF_FFFF_FFFF_FFEB);
        x          = 32'd5;
        y          = 32'd6;
        mul_signed = 1'b0;
        in_valid   = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_p", p, 64'hFFFF_FFFF_FFFF_FFEB);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_consumed_valid", 64'(out_valid), 64'd0);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("bp_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_done(lat);
        check("bp2_lat", 64'(lat), 64'd17);
        check("bp2_p", p, 64'd30);
        consume(0, 64'd30);

        // out_ready already high when DONE is entered: one-cycle valid pulse
        start_op(32'd3, 32'd4, 1'b0);
        out_ready = 1'b1;
        wait_done(lat);
        check("pulse_lat", 64'(lat), 64'd17);
        check("pulse_p", p, 64'd12);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pulse_valid_drop", 64'(out_valid), 64'd0);
        check("pulse_ready_back", 64'(in_ready), 64'd1);
        check("pulse_p_kept", p, 64'd12);

        // Reset while count==8 discards the in-flight operation
        start_op(32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_p", p, 64'h0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_no_result", 64'(out_valid), 64'd0);
        start_op(32'd123456, 32'd654321, 1'b0);
        wait_done(lat);
        check("post_rst_lat", 64'(lat), 64'd17);
        check("post_rst_p", p, 64'h0000_0012_CEDA_BE40);
        consume(0, 64'h0000_0012_CEDA_BE40);

        // Randomized regression with stalls, including the boundary operands
        for (int n = 0; n < 2000; n++) begin
            a = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            b = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : $urandom;
            s = 1'($urandom);
            exp = ref_mul(a, b, s);
            start_op(a, b, s);
            wait_done(lat);
            check("rnd_lat", 64'(lat), 64'd17);
            n_tests++;
            if (p !== exp) begin
                n_fail++;
                $display("FAIL rnd_p a=%h b=%h s=%0d: got %h, expected %h",
                         a, b, s, p, exp);
            end
            consume($urandom_range(3), exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
